// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if
// Bundles the command, ALU-issue and response channels of alu_cmd_issuer.
//   slave  : issuer side (accepts commands, drives the ALU, returns responses)
//   master : environment side (command source, ALU/selector, response sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b : command push channel
//   alu_opcode/alu_a/alu_b/alu_result          : ALU issue and selected result
//   rsp_valid/rsp_ready/rsp_result/rsp_opcode/rsp_illegal : response channel
//   fifo_count, busy                           : status
interface alu_cmd_issuer_if #(
  parameter int W     = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_opcode;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [W-1:0]  alu_opcode;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [W-1:0]  rsp_opcode;
  logic          rsp_illegal;
  logic [CW-1:0] fifo_count;
  logic          busy;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_opcode, rsp_illegal, fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_opcode, rsp_illegal, fifo_count, busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Buffers ALU commands in a DEPTH-entry FIFO, issues them one at a time on
// alu_opcode/alu_a/alu_b, captures alu_result ALU_LAT cycles later and returns
// it with the opcode on a valid/ready response channel, in command order.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_cmd_issuer_if.slave (command, ALU issue, response, status)
// Optional feature macro: ALU_CMD_ILLEGAL_CHECK_EN
//   defined   : opcodes outside the ten alu_ops codes (0..9) are not issued;
//               they answer one cycle later with rsp_illegal=1, rsp_result=0.
//   undefined : every opcode is issued; rsp_illegal is tied low.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the FIFO head when present
// WAIT  | command issued, counting ALU latency
// HOLD  | response valid, waiting for rsp_ready
module alu_cmd_issuer #(
  parameter int W       = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  alu_cmd_issuer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;

  logic [3*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic [W-1:0] alu_opcode_q, alu_a_q, alu_b_q;
  logic [W-1:0] rsp_result_q, rsp_opcode_q;
  logic         rsp_valid_q;

  logic         empty, full, push, pop;
  logic [W-1:0] head_op, head_a, head_b;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // cmd_ready looks only at the registered count, so a same-cycle pop never
  // opens a slot early.
  assign bus.cmd_ready = !rst && !full;
  assign push  = bus.cmd_valid && bus.cmd_ready;
  assign pop   = (state == IDLE) && !empty;
  assign {head_op, head_a, head_b} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_CMD_ILLEGAL_CHECK_EN
  logic rsp_illegal_q;
  logic head_legal;
  assign head_legal = (head_op < W'(10));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      alu_opcode_q  <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_opcode_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          if (head_legal) begin
            alu_opcode_q <= head_op;
            alu_a_q      <= head_a;
            alu_b_q      <= head_b;
            lat_cnt      <= '0;
            state        <= WAIT;
          end else begin
            // Illegal opcode bypasses the ALU; alu_* keep their last values.
            rsp_result_q  <= '0;
            rsp_opcode_q  <= head_op;
            rsp_illegal_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state         <= HOLD;
          end
        end
        WAIT: if (lat_cnt == LW'(ALU_LAT - 1)) begin
          rsp_result_q  <= bus.alu_result;
          rsp_opcode_q  <= alu_opcode_q;
          rsp_illegal_q <= 1'b0;
          rsp_valid_q   <= 1'b1;
          state         <= HOLD;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
        HOLD: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_illegal = rsp_illegal_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          alu_opcode_q <= head_op;
          alu_a_q      <= head_a;
          alu_b_q      <= head_b;
          lat_cnt      <= '0;
          state        <= WAIT;
        end
        WAIT: if (lat_cnt == LW'(ALU_LAT - 1)) begin
          rsp_result_q <= bus.alu_result;
          rsp_opcode_q <= alu_opcode_q;
          rsp_valid_q  <= 1'b1;
          state        <= HOLD;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
        HOLD: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_illegal = 1'b0;
`endif

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != IDLE);
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the ALU datapath: buffers operation requests (opcode plus two operands) in a small FIFO and issues them one at a time on the opcode/operand lines that feed the ALU operation units and result selector. After a fixed ALU latency it captures the selected result and returns it, tagged with the opcode, on a valid/ready response channel. It is the producer of the `alu_ops` opcodes that the result selector decodes, and it sits between the command source (testbench, sequencer or board I/O) and the ALU.

## Interface

- `W`, 4: data and opcode width. Opcodes are encoded per the `alu_ops` package.
- `DEPTH`, 4: command FIFO depth. Power of two, ≥2.
- `ALU_LAT`, 1: cycles from the `alu_*` registers updating to `alu_result` being valid. Must be ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_opcode` in W: requested operation.
- `cmd_a` in W: operand A.
- `cmd_b` in W: operand B.
- `alu_opcode` out W: registered opcode driven to the ALU and selector.
- `alu_a` out W: registered operand A.
- `alu_b` out W: registered operand B.
- `alu_result` in W: selected ALU result.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out W: captured result.
- `rsp_opcode` out W: opcode of the command that produced `rsp_result`.
- `rsp_illegal` out 1: the command's opcode is not one of the ten defined `alu_ops`.
- `fifo_count` out $clog2(DEPTH)+1: number of queued commands.
- `busy` out 1: FSM is not in IDLE.

## Operation

- **Push.** A command is written when `cmd_valid && cmd_ready` at a rising edge.
  - `cmd_ready = !rst && (fifo_count < DEPTH)`.
  - A pop in the same cycle does not raise `cmd_ready`. There is no push when full.
- **FSM states:** IDLE, WAIT, HOLD.
- **IDLE**
  - If the FIFO is not empty and the head opcode is legal: load `alu_opcode`/`alu_a`/`alu_b` from the head, pop, clear the counter, go to WAIT.
  - If the FIFO is empty: stay in IDLE. `alu_*` hold their last values.
- **WAIT**
  - The counter increments each cycle.
  - When counter == ALU_LAT-1: capture `alu_result` into `rsp_result` and `alu_opcode` into `rsp_opcode`, clear `rsp_illegal`, set `rsp_valid`, go to HOLD.
- **HOLD**
  - `rsp_*` are stable while `rsp_valid && !rsp_ready`.
  - When `rsp_ready`: clear `rsp_valid`, go to IDLE.
  - `rsp_result`/`rsp_opcode` keep their values after the handshake.
- **FIFO pointers** wrap modulo DEPTH. `fifo_count` changes by +1, −1 or 0; a simultaneous push and pop leaves it unchanged.
- **Order.** Responses come back in command order. Exactly one response is produced per accepted command.

## Timing

- **Reset values** (applied immediately on `rst` assertion, asynchronously):
  - `alu_opcode`, `alu_a`, `alu_b`, `rsp_result`, `rsp_opcode` = 0.
  - `rsp_valid`, `rsp_illegal`, `busy` = 0.
  - `fifo_count` = 0, FSM in IDLE.
  - `cmd_ready` = 0 while `rst` is high and 1 on the first cycle after release.
- **Reset mid-operation:** queued commands and any in-flight or held response are discarded. No response is produced for them.
- **Legal command, empty FIFO, IDLE, accepted at edge E:**
  - `alu_*` update at E+1.
  - `rsp_valid` rises at E+1+ALU_LAT.
- **Illegal command:** see Configuration. With the check compiled in, `rsp_valid` rises at E+1.
- **Throughput:** with `rsp_ready` tied high, one legal command every ALU_LAT+2 cycles. The HOLD→IDLE transition costs one cycle.
- **`busy`** is high in WAIT and HOLD.

## Configuration

- **`ALU_CMD_ILLEGAL_CHECK_EN` defined:**
  - In IDLE, a head opcode outside the ten `alu_ops` codes is popped without issue; `alu_*` are unchanged.
  - At the next edge: `rsp_result` = 0, `rsp_opcode` = that opcode, `rsp_illegal` = 1, `rsp_valid` = 1; the FSM enters HOLD directly.
- **Not defined:**
  - Every opcode is issued through WAIT like a legal one; the selector's default path supplies the result.
  - `rsp_illegal` is tied to 0.

## Test plan

- **Single ADD.** Reset, W=4, ALU_LAT=1. Push ADD_OP, a=3, b=5 at edge E.
  - `alu_opcode` = ADD_OP at E+1.
  - `rsp_valid` at E+2 with `rsp_result` = 8 and `rsp_opcode` = ADD_OP.
- **Fill and backpressure.** Hold `rsp_ready` = 0 and push 6 commands back-to-back.
  - `cmd_ready` drops once `fifo_count` = 4, with one command in HOLD.
  - Raise `rsp_ready`: all 5 accepted commands return in order with correct results; the rejected sixth never appears.
- **Pointer wrap.** Stream 10 SUB_OP commands with a=i, b=1.
  - Results are i−1 mod 16, in order.
  - `fifo_count` never exceeds 4.
- **Response hold.** Hold `rsp_ready` low for 5 cycles.
  - `rsp_valid`/`rsp_result` stay stable.
  - `alu_*` do not change until the handshake completes.
- **Reset mid-operation.** Assert `rst` in WAIT with 2 commands queued.
  - All outputs go to 0 immediately.
  - After release, `fifo_count` = 0 and no response appears.
- **Illegal opcode (macro defined).** Push an unused opcode (e.g. 4'hF).
  - One cycle later: `rsp_illegal` = 1, `rsp_result` = 0, `alu_*` unchanged.
  - Without the macro, the response equals the selector's default-path result and `rsp_illegal` = 0.
